div_sequencer: RTL and testbench

Issue/response sequencer sitting directly upstream of the 32-bit restoring divider in the multdiv unit. It accepts one divide request at a time from the pipeline over a valid/ready handshake, registers and holds the operands stable for the divider, and pulses the divider's start control. It counts the divider's iterations, captures the quotient and exception flag, and presents them with the request tag on a valid/ready response port.

---
 rtl/div_sequencer.sv | 143 ++++++++++++++
 tb/tb_div_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: issue/response sequencer in front of the multi-cycle restoring divider.
// Optional feature macro EARLY_DIV0_EN: divide-by-zero requests retire straight from IDLE without starting the divider.
module div_sequencer #(
    parameter int LAT   = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [31:0]      div_operandA,
    output logic [31:0]      div_operandB,
    output logic             div_ctrl,
    input  logic [31:0]      div_result,
    input  logic             div_exception,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_exception,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and data is held stable while valid is high.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(LAT - 1);

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic [31:0]      res_q, res_d;
    logic             exc_q, exc_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             accept;

    assign req_ready = (state_q == IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        exc_d    = exc_q;
        tag_d    = tag_q;
        div_ctrl = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    opa_d = req_a;
                    opb_d = req_b;
                    tag_d = req_tag;
`ifdef EARLY_DIV0_EN
                    if (req_b == 32'd0) begin
                        res_d   = 32'd0;
                        exc_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                div_ctrl = 1'b1;
                cnt_d    = 6'd1;
                state_d  = BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q + 6'd1;
                // The divider output is only meaningful in its final iteration cycle.
                if (cnt_q == CNT_LAST) begin
                    res_d   = div_result;
                    exc_d   = div_exception;
                    cnt_d   = 6'd0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything; operands keep their last accepted value.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
            res_d   = res_q;
            exc_d   = exc_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            res_q   <= 32'd0;
            exc_q   <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            tag_q   <= tag_d;
        end
    end

    assign div_operandA  = opa_q;
    assign div_operandB  = opb_q;
    assign rsp_valid     = (state_q == DONE);
    assign rsp_result    = res_q;
    assign rsp_exception = exc_q;
    assign rsp_tag       = tag_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: behavioural divider, reference quotient model and response scoreboard.
`timescale 1ns/1ps
module tb_div_sequencer;

    localparam int LAT   = 32;
    localparam int TAG_W = 5;
    localparam int RW    = TAG_W + 33;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_a = 32'd0;
    logic [31:0]      req_b = 32'd0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             flush = 1'b0;
    logic [31:0]      div_operandA;
    logic [31:0]      div_operandB;
    logic             div_ctrl;
    logic [31:0]      div_result;
    logic             div_exception;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_exception;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic [1:0]       dbg_state;

    div_sequencer #(.LAT(LAT), .TAG_W(TAG_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_tag       (req_tag),
        .flush         (flush),
        .div_operandA  (div_operandA),
        .div_operandB  (div_operandB),
        .div_ctrl      (div_ctrl),
        .div_result    (div_result),
        .div_exception (div_exception),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_exception (rsp_exception),
        .rsp_tag       (rsp_tag),
        .busy          (busy),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ctrl_pulses = 0;
    int rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random
    bit in_rsp = 1'b0;

    logic [RW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            exp_pulse_q[$];
    int            rsp_cyc_log[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        if (rdy_mode == 1)      rsp_ready = 1'b1;
        else if (rdy_mode == 2) rsp_ready = 1'($urandom_range(0, 1));
        else                    rsp_ready = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Quotient truncated toward zero; divide by zero gives 0 with the exception flag.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q;
        if (b == 32'd0) return {1'b1, 32'd0};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        return {1'b0, q[31:0]};
    endfunction

    function automatic bit early_path(input logic [31:0] b);
`ifdef EARLY_DIV0_EN
        return (b == 32'd0);
`else
        return (b == 32'd0) && 1'b0;
`endif
    endfunction

    // Behavioural divider: output is correct only in its last iteration cycle, garbage otherwise.
    int          dv_cnt;
    logic [32:0] dv_true;

    always @(posedge clock or negedge reset) begin
        if (!reset)                          dv_cnt <= 0;
        else if (div_ctrl)                   dv_cnt <= 1;
        else if (dv_cnt != 0 && dv_cnt < 100) dv_cnt <= dv_cnt + 1;
    end

    always_comb begin
        dv_true = ref_div(div_operandA, div_operandB);
        if (dv_cnt == LAT - 1) begin
            div_result    = dv_true[31:0];
            div_exception = dv_true[32];
        end else begin
            div_result    = dv_true[31:0] ^ 32'hA5A5_5A5A;
            div_exception = ~dv_true[32];
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (!reset) begin
            in_rsp = 1'b0;
        end else begin
            if (div_ctrl) ctrl_pulses++;
            if (!flush) check("busy_vs_ready", {63'd0, busy}, {63'd0, !req_ready});
            if (rsp_valid) begin
                check("ready_low_in_done", {63'd0, req_ready}, 64'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got tag %0d result %0h, expected no response (t=%0t)",
                             rsp_tag, rsp_result, $time);
                end else begin
                    check("rsp_data", {26'd0, rsp_tag, rsp_exception, rsp_result}, {26'd0, exp_q[0]});
                    if (!in_rsp) begin
                        check("rsp_latency", 64'(cyc), 64'(exp_cyc_q[0]));
                        check("div_ctrl_pulses", 64'(ctrl_pulses), 64'(exp_pulse_q[0]));
                        ctrl_pulses = 0;
                        rsp_cyc_log.push_back(cyc);
                    end
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        void'(exp_cyc_q.pop_front());
                        void'(exp_pulse_q.pop_front());
                    end
                end
                in_rsp = !rsp_ready;
            end else begin
                in_rsp = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input bit expect_rsp);
        int          waited = 0;
        bit          done = 1'b0;
        logic [32:0] r;
        req_a = a;
        req_b = b;
        req_tag = tag;
        req_valid = 1'b1;
        while (!done) begin
            @(negedge clock);
            if (req_ready && !flush) begin
                done = 1'b1;
                if (expect_rsp) begin
                    r = ref_div(a, b);
                    exp_q.push_back({tag, r});
                    exp_cyc_q.push_back(cyc + 1 + (early_path(b) ? 0 : LAT));
                    exp_pulse_q.push_back(early_path(b) ? 0 : 1);
                end
            end else if (++waited > 300) begin
                check("req_accept_timeout", 64'(waited), 64'd0);
                done = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag_s);
        check({tag_s, "_busy"},      {63'd0, busy},          64'd0);
        check({tag_s, "_req_ready"}, {63'd0, req_ready},     64'd1);
        check({tag_s, "_rsp_valid"}, {63'd0, rsp_valid},     64'd0);
        check({tag_s, "_div_ctrl"},  {63'd0, div_ctrl},      64'd0);
        check({tag_s, "_opA"},       {32'd0, div_operandA},  64'd0);
        check({tag_s, "_opB"},       {32'd0, div_operandB},  64'd0);
        check({tag_s, "_result"},    {32'd0, rsp_result},    64'd0);
        check({tag_s, "_exc"},       {63'd0, rsp_exception}, 64'd0);
        check({tag_s, "_tag"},       {59'd0, rsp_tag},       64'd0);
        check({tag_s, "_state"},     {62'd0, dbg_state},     64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] a, b;
        int          base;
        int          n;

        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("reset");
        @(posedge clock);
        #3;
        reset = 1'b1;
        rdy_mode = 1;
        @(posedge clock);
        #1;

        // basic divide
        do_req(32'd100, 32'd7, 5'd3, 1'b1);
        wait_drain("drain_basic");

        // back-to-back signed operations
        base = rsp_cyc_log.size();
        do_req(-32'sd100, 32'd7, 5'd1, 1'b1);
        do_req(32'd100, -32'sd7, 5'd2, 1'b1);
        wait_drain("drain_b2b");
        check("b2b_count", 64'(rsp_cyc_log.size()), 64'(base + 2));
        if (rsp_cyc_log.size() >= base + 2)
            check("b2b_spacing", 64'(rsp_cyc_log[base+1] - rsp_cyc_log[base]), 64'(LAT + 2));

        // divide by zero
        do_req(32'd7, 32'd0, 5'd9, 1'b1);
        wait_drain("drain_div0");

        // consumer back-pressure
        rdy_mode = 0;
        @(posedge clock);
        #1;
        do_req(32'd1234, -32'sd5, 5'd21, 1'b1);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        repeat (10) @(negedge clock);
        check("hold_valid", {63'd0, rsp_valid}, 64'd1);
        rdy_mode = 1;
        wait_drain("drain_hold");

        // flush mid-operation with a competing request
        do_req(32'd500, 32'd3, 5'd7, 1'b0);
        repeat (10) @(posedge clock);
        #1;
        flush = 1'b1;
        req_valid = 1'b1;
        req_a = 32'd77;
        req_b = 32'd7;
        req_tag = 5'd5;
        @(negedge clock);
        check("flush_blocks_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clock);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        check("flush_idle", {63'd0, busy}, 64'd0);
        check("flush_no_valid", {63'd0, rsp_valid}, 64'd0);
        check("flush_keeps_opA", {32'd0, div_operandA}, 64'd500);
        ctrl_pulses = 0;
        repeat (LAT + 5) @(negedge clock);
        check("flush_no_issue", 64'(ctrl_pulses), 64'd0);
        @(posedge clock);
        #1;
        do_req(32'd50, 32'd5, 5'd4, 1'b1);
        wait_drain("drain_after_flush");

        // asynchronous reset mid-operation
        do_req(32'd999, 32'd4, 5'd11, 1'b0);
        repeat (20) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        ctrl_pulses = 0;
        repeat (LAT + 5) @(negedge clock);
        check("midreset_no_issue", 64'(ctrl_pulses), 64'd0);
        check("midreset_idle", {63'd0, busy}, 64'd0);

        // randomized traffic with random back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 20)) : -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 2) == 0) a = 32'($urandom_range(0, 1000));
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
            do_req(a, b, 5'($urandom_range(0, 31)), 1'b1);
        end
        rdy_mode = 1;
        wait_drain("drain_random");

        repeat (5) @(posedge clock);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
